// File: rtl/tournament_predictor_q.sv
// Tournament branch-direction predictor: gshare + lshare + selector, with an in-flight queue.
// Latency: pred_taken/mispredict combinational; table, queue and GHR writes land on the next clk.
// Backpressure: pred_ready drops when the queue is full; the frontend must stall lookups until it rises.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   i_en                   global enable (0 freezes all state)
//   i_lookup_valid/_pc/_fallback   fetch-side conditional branch lookup
//   o_pred_taken           direction prediction for i_lookup_pc
//   o_pred_ready           queue not full
//   i_resolve_valid/_taken in-order resolution of the oldest queued branch
//   o_mispredict           resolution disagrees with the head prediction
//   o_count                number of queued predictions
//
// Build option: define BP_SPEC_GHR_EN to update the GHR speculatively at each push and
// repair it from a per-entry checkpoint on mispredict; otherwise the GHR only sees
// resolved outcomes.
module tournament_predictor_q #(
  parameter int IWIDTH = 10,
  parameter int HWIDTH = 8,
  parameter int CWIDTH = 2,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_en,
  input  logic                      i_lookup_valid,
  input  logic [31:0]               i_lookup_pc,
  input  logic                      i_lookup_fallback,
  output logic                      o_pred_taken,
  output logic                      o_pred_ready,
  input  logic                      i_resolve_valid,
  input  logic                      i_resolve_taken,
  output logic                      o_mispredict,
  output logic [$clog2(QDEPTH):0]   o_count
);

  localparam int QW   = $clog2(QDEPTH);
  localparam int NENT = 1 << IWIDTH;
  localparam logic [CWIDTH-1:0] C_WT   = {1'b1, {(CWIDTH-1){1'b0}}};  // weakly taken
  localparam logic [CWIDTH-1:0] C_WN   = {1'b0, {(CWIDTH-1){1'b1}}};  // weakly not-taken
  localparam logic [QW:0]       C_FULL = (QW+1)'(QDEPTH);

  typedef struct packed {
    logic [IWIDTH-1:0] tag;
    logic [IWIDTH-1:0] gidx;
    logic [IWIDTH-1:0] lidx;
    logic              gpred;
    logic              lpred;
    logic              sel;
    logic              pred;
`ifdef BP_SPEC_GHR_EN
    logic [HWIDTH-1:0] ghr;
`endif
  } qent_t;

  // First touch of an entry lands it on the weak state of the observed outcome.
  function automatic logic [CWIDTH-1:0] f_ctr_next(input logic vld,
                                                   input logic [CWIDTH-1:0] ctr,
                                                   input logic t);
    logic [CWIDTH-1:0] nxt;
    nxt = ctr;
    if (!vld)
      nxt = t ? C_WT : C_WN;
    else if (t && (ctr != '1))
      nxt = ctr + CWIDTH'(1);
    else if (!t && (ctr != '0))
      nxt = ctr - CWIDTH'(1);
    return nxt;
  endfunction

  // Prediction tables. Counters carry no reset; the valid bits gate them.
  logic [NENT-1:0]   r_g_vld;
  logic [NENT-1:0]   r_l_vld;
  logic [NENT-1:0]   r_s_vld;
  logic [CWIDTH-1:0] r_g_ctr [NENT];
  logic [CWIDTH-1:0] r_l_ctr [NENT];
  logic [CWIDTH-1:0] r_s_ctr [NENT];
  logic [HWIDTH-1:0] r_bht   [NENT];
  logic [HWIDTH-1:0] r_ghr;

  // In-flight queue
  qent_t             r_q [QDEPTH];
  logic [QW-1:0]     r_wptr;
  logic [QW-1:0]     r_rptr;
  logic [QW:0]       r_count;

  logic [IWIDTH-1:0] w_tag;
  logic [IWIDTH-1:0] w_ghr_x;
  logic [IWIDTH-1:0] w_bht_x;
  logic [IWIDTH-1:0] w_gidx;
  logic [IWIDTH-1:0] w_lidx;
  logic              w_gpred;
  logic              w_lpred;
  logic              w_sel;
  logic              w_nonempty;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_t;
  qent_t             w_head;
  qent_t             w_new;
  logic              w_unused;

  assign w_tag = i_lookup_pc[IWIDTH+1:2];

  // Histories are zero-extended to the index width before hashing.
  always_comb begin
    w_ghr_x = '0;
    w_bht_x = '0;
    w_ghr_x[HWIDTH-1:0] = r_ghr;
    w_bht_x[HWIDTH-1:0] = r_bht[w_tag];
  end

  assign w_gidx  = w_tag ^ w_ghr_x;
  assign w_lidx  = w_tag ^ w_bht_x;
  assign w_gpred = r_g_vld[w_gidx] ? r_g_ctr[w_gidx][CWIDTH-1] : i_lookup_fallback;
  assign w_lpred = r_l_vld[w_lidx] ? r_l_ctr[w_lidx][CWIDTH-1] : i_lookup_fallback;
  // An untrained selector entry defaults to gshare.
  assign w_sel   = r_s_vld[w_tag] & r_s_ctr[w_tag][CWIDTH-1];

  assign o_pred_taken = w_sel ? w_lpred : w_gpred;

  assign w_head       = r_q[r_rptr];
  assign w_nonempty   = (r_count != '0);
  assign w_t          = i_resolve_taken;
  assign o_count      = r_count;
  assign o_pred_ready = (r_count != C_FULL);
  assign o_mispredict = i_resolve_valid & w_nonempty & (i_resolve_taken != w_head.pred);

  assign w_pop   = i_resolve_valid & i_en & w_nonempty;
  assign w_flush = w_pop & o_mispredict;
  // A mispredict kills everything younger, including a lookup in the same cycle.
  assign w_push  = i_lookup_valid & i_en & o_pred_ready & ~o_mispredict;

  always_comb begin
    w_new       = '0;
    w_new.tag   = w_tag;
    w_new.gidx  = w_gidx;
    w_new.lidx  = w_lidx;
    w_new.gpred = w_gpred;
    w_new.lpred = w_lpred;
    w_new.sel   = w_sel;
    w_new.pred  = o_pred_taken;
`ifdef BP_SPEC_GHR_EN
    w_new.ghr   = r_ghr;
`endif
  end

  // The selector choice is kept with each entry for debug visibility only.
  assign w_unused = ^{i_lookup_pc[31:IWIDTH+2], i_lookup_pc[1:0], w_head.sel};

  // Queue pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + QW'(1);
      if (w_pop)  r_rptr <= r_rptr + QW'(1);
      r_count <= r_count + (QW+1)'(w_push) - (QW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wptr] <= w_new;
  end

  // Valid bits and local histories
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_g_vld <= '0;
      r_l_vld <= '0;
      r_s_vld <= '0;
      for (int i = 0; i < NENT; i++) r_bht[i] <= '0;
    end else if (w_pop) begin
      r_g_vld[w_head.gidx] <= 1'b1;
      r_l_vld[w_head.lidx] <= 1'b1;
      if (w_head.gpred != w_head.lpred) r_s_vld[w_head.tag] <= 1'b1;
      r_bht[w_head.tag] <= {r_bht[w_head.tag][HWIDTH-2:0], w_t};
    end
  end

  // Counters; the selector trains toward lshare when lshare was right.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_g_ctr[w_head.gidx] <= f_ctr_next(r_g_vld[w_head.gidx], r_g_ctr[w_head.gidx], w_t);
      r_l_ctr[w_head.lidx] <= f_ctr_next(r_l_vld[w_head.lidx], r_l_ctr[w_head.lidx], w_t);
      if (w_head.gpred != w_head.lpred)
        r_s_ctr[w_head.tag] <= f_ctr_next(r_s_vld[w_head.tag], r_s_ctr[w_head.tag],
                                          w_head.lpred == w_t);
    end
  end

  // Global history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ghr <= '0;
    end else begin
`ifdef BP_SPEC_GHR_EN
      if (w_flush)
        r_ghr <= {w_head.ghr[HWIDTH-2:0], w_t};
      else if (w_push)
        r_ghr <= {r_ghr[HWIDTH-2:0], o_pred_taken};
`else
      if (w_pop)
        r_ghr <= {r_ghr[HWIDTH-2:0], w_t};
`endif
    end
  end

endmodule
